uart_response_arbiter: RTL and testbench



---
 rtl/uart_bridge_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/uart_response_arbiter.sv | 105 ++++++++++
 tb/tb_uart_response_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared constants and state encoding for the UART host-link response path.
package uart_bridge_pkg;

    localparam int unsigned PKT_BYTES_DEFAULT = 16;
    localparam int unsigned PKT_W             = 128;
    localparam int unsigned CHAN_D_ID         = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            // One extra bit so rr_ptr + off never overflows before the wrap compare.
            w_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(off);
            if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_response_arbiter.sv
// Round-robin sharing of the UART TX byte path among packet producers;
// latches the granted packet and streams it out byte 0 first.
module uart_response_arbiter
    import uart_bridge_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned PKT_BYTES = PKT_BYTES_DEFAULT,
    localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*PKT_BYTES*8-1:0] req_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [7:0]                     tx_byte,
    output logic                           busy,
    output logic [IDX_W-1:0]               grant_id
);

    localparam int unsigned PKT_BITS = PKT_BYTES * 8;
    localparam int unsigned CNT_W    = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

    state_e                r_state,     w_state_d;
    logic [IDX_W-1:0]      r_rr_ptr,    w_rr_ptr_d;
    logic [CNT_W-1:0]      r_byte_cnt,  w_byte_cnt_d;
    logic [PKT_BITS-1:0]   r_pkt_buf,   w_pkt_buf_d;
    logic [IDX_W-1:0]      r_grant_id,  w_grant_id_d;

    logic [NUM_REQ-1:0]    w_gnt;
    logic [IDX_W-1:0]      w_gnt_idx;
    logic [PKT_BITS-1:0]   w_sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .rr_ptr  (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = req_data[i*PKT_BITS +: PKT_BITS];
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_rr_ptr_d   = r_rr_ptr;
        w_byte_cnt_d = r_byte_cnt;
        w_pkt_buf_d  = r_pkt_buf;
        w_grant_id_d = r_grant_id;
        unique case (r_state)
            IDLE: begin
                // A grant implies the matching valid, so this is the accept handshake.
                if (|w_gnt) begin
                    w_state_d    = SEND;
                    w_pkt_buf_d  = w_sel_data;
                    w_grant_id_d = w_gnt_idx;
                    w_byte_cnt_d = '0;
                    w_rr_ptr_d   = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (r_byte_cnt == CNT_W'(PKT_BYTES - 1)) begin
                        w_state_d = IDLE;
                    end else begin
                        w_byte_cnt_d = r_byte_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_byte_cnt <= '0;
            r_pkt_buf  <= '0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_state_d;
            r_rr_ptr   <= w_rr_ptr_d;
            r_byte_cnt <= w_byte_cnt_d;
            r_pkt_buf  <= w_pkt_buf_d;
            r_grant_id <= w_grant_id_d;
        end
    end

    assign req_ready = (r_state == IDLE) ? w_gnt : '0;
    assign tx_valid  = (r_state == SEND);
    assign tx_byte   = tx_valid ? r_pkt_buf[{r_byte_cnt, 3'b000} +: 8] : 8'h00;
    assign busy      = (r_state == SEND);
    assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_uart_response_arbiter.sv
// Directed-plus-random bench for uart_response_arbiter (NUM_REQ=2 main DUT, NUM_REQ=3 wrap DUT).
module tb_uart_response_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   req_valid, req_ready;
    logic [255:0] req_data;
    logic         tx_valid, tx_ready, busy;
    logic [7:0]   tx_byte;
    logic [0:0]   grant_id;

    logic [2:0]   b_req_valid, b_req_ready;
    logic [383:0] b_req_data;
    logic         b_tx_valid, b_tx_ready, b_busy;
    logic [7:0]   b_tx_byte;
    logic [1:0]   b_grant_id;

    int n_checks;
    int n_err;
    int model_ptr;

    always #5 clk = ~clk;

    uart_response_arbiter #(.NUM_REQ(2), .PKT_BYTES(16)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_byte   (tx_byte),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    uart_response_arbiter #(.NUM_REQ(3), .PKT_BYTES(16)) u_dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_data  (b_req_data),
        .tx_valid  (b_tx_valid),
        .tx_ready  (b_tx_ready),
        .tx_byte   (b_tx_byte),
        .busy      (b_busy),
        .grant_id  (b_grant_id)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference arbitration: lowest modular distance from the pointer wins.
    function automatic int pick(input logic [1:0] v, input int ptr);
        for (int off = 0; off < 2; off++) begin
            int i;
            i = (ptr + off) % 2;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic recv_pkt(input string tag, input bit rand_rdy, input bit mutate,
                            input int nbytes, input int exp_wait);
        int g, w, k, cyc;
        logic [127:0] pkt;
        bit prev_hold;
        logic [7:0] prev_byte;
        g = pick(req_valid, model_ptr);
        w = 0;
        #1;
        while (!(|req_ready) && w < 40) begin
            tick();
            w++;
        end
        chk({tag, "_ready_seen"}, 128'(|req_ready), 128'(1));
        if (exp_wait >= 0) chk({tag, "_idle_wait"}, 128'(w), 128'(exp_wait));
        chk({tag, "_req_ready"}, 128'(req_ready), 128'(1) << g);
        pkt = req_data[g*128 +: 128];
        tick();
        model_ptr = (g + 1) % 2;
        chk({tag, "_grant_id"}, 128'(grant_id), 128'(g));
        chk({tag, "_busy"}, 128'(busy), 128'(1));
        if (mutate) req_data = {rand128(), rand128()};
        k = 0;
        cyc = 0;
        prev_hold = 1'b0;
        prev_byte = 8'h00;
        while (k < nbytes && cyc < 400) begin
            tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            chk({tag, "_tx_valid"}, 128'(tx_valid), 128'(1));
            chk({tag, "_no_ready_in_send"}, 128'(req_ready), 128'(0));
            if (prev_hold) chk({tag, "_hold_byte"}, 128'(tx_byte), 128'(prev_byte));
            if (tx_ready) begin
                chk({tag, "_byte"}, 128'(tx_byte), 128'(pkt[8*k +: 8]));
                k++;
            end
            prev_hold = !tx_ready;
            prev_byte = tx_byte;
            tick();
            cyc++;
        end
        chk({tag, "_byte_count"}, 128'(k), 128'(nbytes));
        if (nbytes == 16) begin
            if (!rand_rdy) chk({tag, "_cycles"}, 128'(cyc), 128'(16));
            chk({tag, "_busy_after"}, 128'(busy), 128'(0));
            chk({tag, "_tx_valid_after"}, 128'(tx_valid), 128'(0));
            chk({tag, "_grant_id_after"}, 128'(grant_id), 128'(g));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_err       = 0;
        model_ptr   = 0;
        reset_n     = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        tx_ready    = 1'b0;
        b_req_valid = '0;
        b_req_data  = '0;
        b_tx_ready  = 1'b1;
        #12;
        chk("rst_tx_valid", 128'(tx_valid), 128'(0));
        chk("rst_tx_byte", 128'(tx_byte), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_grant_id", 128'(grant_id), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_b_busy", 128'(b_busy), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Three requesters, only #2 valid from pointer 0; pointer must then wrap to 0.
        b_req_data  = {rand128(), rand128(), rand128()};
        b_req_valid = 3'b100;
        #1;
        chk("wrap_req_ready", 128'(b_req_ready), 128'(3'b100));
        tick();
        chk("wrap_grant_id", 128'(b_grant_id), 128'(2));
        chk("wrap_busy", 128'(b_busy), 128'(1));
        chk("wrap_byte0", 128'(b_tx_byte), 128'(b_req_data[256 +: 8]));
        b_req_valid = 3'b101;
        repeat (16) tick();
        chk("wrap_idle", 128'(b_busy), 128'(0));
        chk("wrap_ptr_next", 128'(b_req_ready), 128'(3'b001));
        b_req_valid = 3'b000;

        req_data = {rand128(), rand128()};
        for (int k = 0; k < 16; k++) req_data[8*k +: 8] = 8'(k);
        req_valid = 2'b01;
        recv_pkt("single", 1'b0, 1'b0, 16, 0);
        req_valid = 2'b00;

        req_data  = {rand128(), rand128()};
        req_valid = 2'b11;
        repeat (4) recv_pkt("alt", 1'b0, 1'b0, 16, 0);
        req_valid = 2'b00;
        tick();

        for (int p = 0; p < 6; p++) begin
            req_data  = {rand128(), rand128()};
            req_valid = 2'($urandom_range(1, 3));
            recv_pkt("rnd", 1'b1, (p % 2) == 1, 16, -1);
        end
        req_valid = 2'b00;
        tick();

        // Abandon a packet from requester 0 mid-stream; afterwards 0 must win the tie again.
        req_data  = {rand128(), rand128()};
        req_valid = 2'b01;
        recv_pkt("part", 1'b0, 1'b0, 6, 0);
        req_valid = 2'b00;
        reset_n   = 1'b0;
        #1;
        chk("midrst_tx_valid", 128'(tx_valid), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_tx_byte", 128'(tx_byte), 128'(0));
        chk("midrst_grant_id", 128'(grant_id), 128'(0));
        chk("midrst_req_ready", 128'(req_ready), 128'(0));
        #2;
        reset_n   = 1'b1;
        model_ptr = 0;
        req_data  = {rand128(), rand128()};
        req_valid = 2'b11;
        recv_pkt("after_rst", 1'b0, 1'b0, 16, 0);
        req_valid = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
